bit_8_demux_deser: RTL and testbench
====================================

Name: bit_8_demux_deser

Overview:
- Receive-side counterpart of the 8:1 bit multiplexer.
- The mux serialises an 8-bit word onto one line by stepping a 3-bit select 0..7 (LSB first). This block rebuilds the 8-bit word from that line, bit by bit, into a held parallel output.
- Two addressing modes:
  - internal bit counter (self-stepping);
  - external select, where each bit lands at a caller-supplied index.
- Sits between a serial link or mux output and parallel consumers.

Parameters:
- WIDTH, 8, output word width; must be a power of two.
- SEL_W, 3, select/counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- din  input  1  serial data bit
- din_valid  input  1  din is sampled on this edge when high
- ext_sel_en  input  1  0 = internal counter addressing, 1 = external select addressing
- sel  input  SEL_W  bit index for din when ext_sel_en=1; ignored otherwise
- clear  input  1  synchronous frame abort; also clears dup_err
- dout  output  WIDTH  last completed word
- dout_valid  output  1  one-cycle pulse when dout updates
- busy  output  1  high while a frame is partially collected
- bit_cnt  output  SEL_W  internal counter value (next bit index in internal mode)
- dup_err  output  1  sticky: bit index written twice within one external-mode frame

Behaviour:
- Reset (rst_n=0 at the clk edge) takes priority over everything. It sets:
  - dout=0, dout_valid=0, busy=0, bit_cnt=0, dup_err=0;
  - shadow register=0, written-mask=0, FSM=IDLE.
- FSM states: IDLE, COLLECT.
  - IDLE -> COLLECT on the first accepted bit of a frame.
  - COLLECT -> IDLE on frame completion or clear.
  - busy = (state==COLLECT).
- Internal mode (ext_sel_en=0):
  - Each edge with din_valid=1 writes shadow[bit_cnt]=din, then bit_cnt increments.
  - Writing index WIDTH-1 completes the frame and bit_cnt wraps to 0.
  - Gaps in din_valid stall collection; no timeout.
- External mode (ext_sel_en=1):
  - Each edge with din_valid=1 writes shadow[sel]=din and sets mask[sel].
  - A write to an index whose mask bit is already set sets dup_err. The data still overwrites that bit.
  - The frame completes on the edge where the mask becomes all-ones.
  - bit_cnt holds its value in external mode.
- Completion edge:
  - dout loads the full word, including the bit written on that same edge.
  - dout_valid=1 for exactly the next cycle.
  - Shadow and mask clear, FSM goes to IDLE.
  - Latency: dout is valid in the cycle immediately after the edge that samples the final bit.
- Back-to-back frames: a bit accepted on the cycle right after completion starts a new frame with no lost cycle. dout_valid may pulse every WIDTH cycles.
- dout holds its value between completions; it is never cleared except by reset.
- clear=1 (checked after reset):
  - clears shadow, mask, bit_cnt and dup_err; FSM goes to IDLE.
  - a din_valid on the same edge is discarded;
  - dout is unchanged and no dout_valid pulse is produced.
- Changing ext_sel_en mid-frame is illegal and its behaviour is undefined. Verification must hold ext_sel_en stable whenever busy=1.
- din, sel and ext_sel_en are ignored when din_valid=0.

Test Plan:
- Internal mode: reset, then send 8'hA5 LSB first (1,0,1,0,0,1,0,1) with din_valid held high. Expect:
  - dout=8'hA5 with dout_valid=1 in the cycle after the 8th bit;
  - busy high for cycles 1..7 of the frame;
  - bit_cnt back to 0.
- Internal mode back-to-back: send 8'h01 then 8'h02 continuously. Expect:
  - dout_valid pulses exactly 8 cycles apart;
  - dout=8'h01 then 8'h02, with dout holding 8'h02 afterwards.
- Internal mode with gaps: send 8'h3C with din_valid deasserted for 2 cycles between every bit. Expect:
  - dout=8'h3C;
  - bit_cnt holds its value during the gaps;
  - a single dout_valid pulse.
- External mode: write bits of 8'hC3 in sel order 7,6,...,0. Expect dout=8'hC3 after the sel=0 write, and dup_err=0.
- External mode duplicate: write sel=2 twice (din=0 then din=1), then the remaining 7 indices of 8'h00. Expect:
  - dup_err=1 from the cycle after the second sel=2 write;
  - dout=8'h04;
  - clear returns dup_err to 0.
- Abort: in internal mode send 4 bits, then pulse rst_n=0 for one cycle (repeat the run with clear=1 instead). Expect:
  - bit_cnt=0, busy=0, no dout_valid;
  - with clear, dout keeps its prior value;
  - a following full frame of 8'h5A yields dout=8'h5A.

Source files
------------

// File: rtl/bit_8_demux_deser.sv
// bit_8_demux_deser: rebuilds a parallel word from a serial bit stream
// (receive side of the 8:1 bit mux). Bits arrive one per accepted edge and
// are placed either by a self-stepping counter (LSB first) or at an
// externally supplied index. The finished word is held on dout until the
// next completion or a reset.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, highest priority
//   din        serial data bit
//   din_valid  din (and sel / ext_sel_en) sampled on this edge when high
//   ext_sel_en 0 = internal counter addressing, 1 = external sel addressing
//   sel        bit index for din in external mode
//   clear      synchronous frame abort, also clears dup_err
//   dout       last completed word
//   dout_valid one-cycle pulse in the cycle after a word completes
//   busy       frame partially collected
//   bit_cnt    next bit index in internal mode
//   dup_err    sticky: an index was written twice within one external frame
//
// WIDTH must be a power of two and SEL_W must equal log2(WIDTH).

// Per-bit slice: decides the next shadow/mask bit for one lane of the word.
// Purely combinational; the top holds the flops and gates the write enable.
module bit_8_demux_deser_lane (
    input  logic hit,        // this lane is addressed on the current edge
    input  logic ext,        // external addressing mode
    input  logic din,
    input  logic shadow_bit,
    input  logic mask_bit,
    output logic shadow_nxt,
    output logic mask_nxt,
    output logic dup         // addressed lane was already written this frame
);
    assign shadow_nxt = hit ? din : shadow_bit;
    // The written-mask only tracks external mode; internal mode relies on
    // the counter reaching the top index instead.
    assign mask_nxt   = mask_bit | (hit & ext);
    assign dup        = hit & ext & mask_bit;
endmodule

module bit_8_demux_deser #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             ext_sel_en,
    input  logic [SEL_W-1:0] sel,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic [SEL_W-1:0] bit_cnt,
    output logic             dup_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e             state_q,      state_d;
    logic [WIDTH-1:0]   shadow_q,     shadow_d;
    logic [WIDTH-1:0]   mask_q,       mask_d;
    logic [SEL_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [WIDTH-1:0]   dout_q,       dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               dup_err_q,    dup_err_d;

    // Write-side decode shared by both addressing modes.
    logic [SEL_W-1:0]   wr_idx;
    logic [WIDTH-1:0]   hit;
    logic [WIDTH-1:0]   shadow_wr;    // shadow with this edge's bit merged in
    logic [WIDTH-1:0]   mask_wr;
    logic [WIDTH-1:0]   dup_hit;
    logic               frame_done;

    assign wr_idx = ext_sel_en ? sel : bit_cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign hit[i] = (wr_idx == SEL_W'(i));

        bit_8_demux_deser_lane u_lane (
            .hit        (hit[i]),
            .ext        (ext_sel_en),
            .din        (din),
            .shadow_bit (shadow_q[i]),
            .mask_bit   (mask_q[i]),
            .shadow_nxt (shadow_wr[i]),
            .mask_nxt   (mask_wr[i]),
            .dup        (dup_hit[i])
        );
    end

    // A frame completes on the edge that writes its last bit, so the word
    // handed to dout is the merged one, not the registered shadow.
    assign frame_done = ext_sel_en ? (&mask_wr)
                                   : (bit_cnt_q == SEL_W'(WIDTH - 1));

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        mask_d       = mask_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dup_err_d    = dup_err_q;

        if (clear) begin
            // Abort discards any bit offered on the same edge; dout is kept.
            state_d   = IDLE;
            shadow_d  = '0;
            mask_d    = '0;
            bit_cnt_d = '0;
            dup_err_d = 1'b0;
        end else if (din_valid) begin
            shadow_d = shadow_wr;
            if (ext_sel_en) begin
                mask_d = mask_wr;
                if (|dup_hit) begin
                    dup_err_d = 1'b1;
                end
            end else begin
                // Wraps to 0 naturally after the top index.
                bit_cnt_d = bit_cnt_q + 1'b1;
            end

            if (frame_done) begin
                dout_d       = shadow_wr;
                dout_valid_d = 1'b1;
                shadow_d     = '0;
                mask_d       = '0;
                state_d      = IDLE;
            end else begin
                state_d      = COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            mask_q       <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dup_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            mask_q       <= mask_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dup_err_q    <= dup_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == COLLECT);
    assign bit_cnt    = bit_cnt_q;
    assign dup_err    = dup_err_q;

endmodule

// File: tb/tb_bit_8_demux_deser.sv
// Scoreboard bench for bit_8_demux_deser: the driver applies one edge of
// stimulus at a time and updates a queue/array reference model; completed
// words are pushed into a scoreboard queue that the negedge monitor pops
// whenever dout_valid is seen.
module tb_bit_8_demux_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       ext_sel_en = 1'b0;
    logic [2:0] sel = '0;
    logic       clear = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;
    logic [2:0] bit_cnt;
    logic       dup_err;

    always #5 clk = ~clk;

    bit_8_demux_deser #(.WIDTH(8), .SEL_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .ext_sel_en (ext_sel_en),
        .sel        (sel),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .dup_err    (dup_err)
    );

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model: internal frames are a list of received bits, external
    // frames a map of index -> bit. A word is done when 8 bits are known.
    logic       m_bits[$];
    logic       m_seen[int];
    logic       m_dup  = 1'b0;
    logic [7:0] m_dout = '0;
    logic       m_pulse = 1'b0;
    logic [7:0] sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic finish_word(input logic [7:0] w);
        sb.push_back(w);
        m_dout  = w;
        m_pulse = 1'b1;
    endtask

    task automatic model(input logic v, input logic d, input logic e,
                         input logic [2:0] s, input logic c, input logic r);
        logic [7:0] w;
        m_pulse = 1'b0;
        if (!r) begin
            m_bits.delete(); m_seen.delete(); m_dup = 1'b0; m_dout = '0;
        end else if (c) begin
            m_bits.delete(); m_seen.delete(); m_dup = 1'b0;
        end else if (v) begin
            if (!e) begin
                m_bits.push_back(d);
                if (m_bits.size() == 8) begin
                    w = '0;
                    for (int i = 0; i < 8; i++) w = w + (8'(m_bits[i]) << i);
                    finish_word(w);
                    m_bits.delete();
                end
            end else begin
                if (m_seen.exists(int'(s))) m_dup = 1'b1;
                m_seen[int'(s)] = d;
                if (m_seen.num() == 8) begin
                    w = '0;
                    for (int i = 0; i < 8; i++) w = w + (8'(m_seen[i]) << i);
                    finish_word(w);
                    m_seen.delete();
                end
            end
        end
    endtask

    // One clock edge of stimulus; inputs change on the falling edge.
    task automatic step(input logic v, input logic d, input logic e,
                        input logic [2:0] s, input logic c, input logic r);
        @(negedge clk);
        din_valid = v; din = d; ext_sel_en = e; sel = s; clear = c; rst_n = r;
        @(posedge clk);
        model(v, d, e, s, c, r);
    endtask

    task automatic idle(input int n, input logic e);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom), e, 3'($urandom), 1'b0, 1'b1);
    endtask

    task automatic send_int(input logic [7:0] w, input int gap);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, w[i], 1'b0, 3'($urandom), 1'b0, 1'b1);
            if (i != 7) idle(gap, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("dout_valid", 32'(dout_valid), 32'(m_pulse));
            if (dout_valid) begin
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else chk("dout_word", 32'(dout), 32'(sb.pop_front()));
            end
            chk("dout_hold", 32'(dout), 32'(m_dout));
            chk("busy", 32'(busy), 32'(m_bits.size() != 0 || m_seen.num() != 0));
            chk("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
            chk("dup_err", 32'(dup_err), 32'(m_dup));
        end
    end

    initial begin
        logic [7:0] w;
        int         perm[8];
        int         t;
        logic       mode;

        // Reset state is checked on the first monitored cycle.
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // Internal, continuous, then back-to-back, then gapped.
        send_int(8'hA5, 0);
        idle(2, 1'b0);
        send_int(8'h01, 0);
        send_int(8'h02, 0);
        idle(3, 1'b0);
        send_int(8'h3C, 2);
        idle(2, 1'b0);

        // External: sel 7..0 carrying 8'hC3.
        w = 8'hC3;
        for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b1, 3'(i), 1'b0, 1'b1);
        idle(2, 1'b1);

        // External duplicate on index 2, giving 8'h04 and a sticky dup_err.
        step(1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            if (i != 2) step(1'b1, 1'b0, 1'b1, 3'(i), 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
        idle(1, 1'b0);

        // Abort by reset, then by clear (with a bit offered on the clear edge).
        send_int(8'hFF, 0);
        w = 8'h0F;
        for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        send_int(8'h5A, 0);
        send_int(8'h77, 0);
        for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
        send_int(8'h5A, 0);
        idle(2, 1'b0);

        // Random frames; mode only changes while idle.
        for (int f = 0; f < 150; f++) begin
            mode = 1'($urandom);
            if (!mode) begin
                w = 8'($urandom);
                for (int i = 0; i < 8; i++) begin
                    if ($urandom_range(0, 24) == 0) begin
                        step(1'($urandom), 1'($urandom), 1'b0, 3'($urandom), 1'b1, 1'b1);
                        break;
                    end
                    step(1'b1, w[i], 1'b0, 3'($urandom), 1'b0, 1'b1);
                    idle($urandom_range(0, 1) * $urandom_range(0, 2), 1'b0);
                end
            end else begin
                for (int i = 0; i < 8; i++) perm[i] = i;
                for (int i = 7; i > 0; i--) begin
                    int j;
                    j = $urandom_range(0, i);
                    t = perm[i]; perm[i] = perm[j]; perm[j] = t;
                end
                for (int i = 0; i < 8; i++) begin
                    if ($urandom_range(0, 9) == 0)
                        step(1'b1, 1'($urandom), 1'b1, 3'(perm[$urandom_range(0, 7)]), 1'b0, 1'b1);
                    if ($urandom_range(0, 29) == 0) begin
                        step(1'b1, 1'($urandom), 1'b1, 3'($urandom), 1'b1, 1'b1);
                        break;
                    end
                    if (m_seen.num() == 0 && i != 0) break;  // a dup write finished it early
                    step(1'b1, 1'($urandom), 1'b1, 3'(perm[i]), 1'b0, 1'b1);
                    idle($urandom_range(0, 1), 1'b1);
                end
                // Drain any frame left partial by an early break.
                for (int i = 0; i < 8 && m_seen.num() != 0; i++)
                    if (!m_seen.exists(i)) step(1'b1, 1'($urandom), 1'b1, 3'(i), 1'b0, 1'b1);
                if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
            end
            if ($urandom_range(0, 39) == 0) step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        end

        idle(3, ext_sel_en);
        mon_en = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
